// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- stall/flush/hold controller for the 5-stage 8-bit core.
//
// Resolves three pipeline events and drives the per-register enables:
//   * load-use hazard between the load in EX and its consumer in ID,
//   * taken branch resolved in EX (flush IF/ID, bubble ID/EX),
//   * multi-cycle data-memory access in MEM, with a timeout fault.
// Also keeps saturating performance counters for stall and flush cycles.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   id_instr            ID instruction (rs1 = [7:4], rs2 = [3:0])
//   id_uses_rs1/rs2     ID instruction actually reads rs1 / rs2
//   idex_instr          EX instruction (rd = [11:8])
//   idex_mem_read       EX instruction is a load
//   branch_taken        EX resolved a taken branch
//   exmem_mem_access    MEM stage does a load/store this cycle
//   dmem_ready          data memory completes the access this cycle
//   pc_write_en, ifid_write_en, idex_write_en, exmem_write_en   register enables
//   ifid_flush, idex_bubble, memwb_bubble                       NOP/bubble strobes
//   fault               sticky memory-timeout fault (cleared by rst only)
//   stall_cnt           saturating count of cycles with the PC held
//   flush_cnt           saturating count of branch flushes
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int STALL_CNT_W = 16,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            id_instr,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [15:0]            idex_instr,
  input  logic                   idex_mem_read,
  input  logic                   branch_taken,
  input  logic                   exmem_mem_access,
  input  logic                   dmem_ready,
  output logic                   pc_write_en,
  output logic                   ifid_write_en,
  output logic                   ifid_flush,
  output logic                   idex_write_en,
  output logic                   idex_bubble,
  output logic                   exmem_write_en,
  output logic                   memwb_bubble,
  output logic                   fault,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [7:0]             flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

  localparam logic [7:0] TIMEOUT = MEM_TIMEOUT[7:0];

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       flush_evt;
  logic       stall_evt;

  logic [3:0] rs1, rs2, rd;
  logic       rd_is_zero;
  logic       mem_stall;
  logic       load_use;

  // Instruction bits outside the register fields are irrelevant here.
  logic unused_bits;
  assign unused_bits = ^{id_instr[15:8], idex_instr[15:12], idex_instr[7:0]};

  function automatic logic [STALL_CNT_W-1:0] sat_inc_stall(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] sat_inc_flush(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  assign rs1        = id_instr[7:4];
  assign rs2        = id_instr[3:0];
  assign rd         = idex_instr[11:8];
  assign rd_is_zero = (ZERO_REG_EN != 0) && (rd == 4'd0);
  assign mem_stall  = exmem_mem_access & ~dmem_ready;
  assign load_use   = idex_mem_read & ~rd_is_zero &
                      ((id_uses_rs1 & (rs1 == rd)) | (id_uses_rs2 & (rs2 == rd)));

  always_comb begin
    state_nxt      = state;
    wait_nxt       = wait_cnt;
    pc_write_en    = 1'b0;
    ifid_write_en  = 1'b0;
    ifid_flush     = 1'b0;
    idex_write_en  = 1'b0;
    idex_bubble    = 1'b0;
    exmem_write_en = 1'b0;
    memwb_bubble   = 1'b0;
    flush_evt      = 1'b0;
    if (!rst && state != FAULT) begin
      if (mem_stall) begin
        // Everything up to EX/MEM freezes; the frozen EX instruction means
        // branch and load-use are simply re-evaluated once memory answers.
        memwb_bubble = 1'b1;
        if (state == RUN) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = 8'd1;
        end else if (wait_cnt == TIMEOUT) begin
          state_nxt = FAULT;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end else begin
        state_nxt      = RUN;
        wait_nxt       = 8'd0;
        pc_write_en    = 1'b1;
        ifid_write_en  = 1'b1;
        idex_write_en  = 1'b1;
        exmem_write_en = 1'b1;
        if (branch_taken) begin
          // The branch kills the younger load consumer anyway, so it wins.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_evt   = 1'b1;
        end else if (load_use) begin
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          idex_bubble   = 1'b1;
        end
      end
    end
  end

  assign stall_evt = !rst && (state != FAULT) && !pc_write_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      fault     <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      fault    <= (state_nxt == FAULT);
      if (stall_evt) stall_cnt <= sat_inc_stall(stall_cnt);
      if (flush_evt) flush_cnt <= sat_inc_flush(flush_cnt);
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush/hold controller for the 5-stage 8-bit core.
- Drives write-enables and bubble/flush strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Handles three events: load-use hazards between ID and EX, taken branches resolved in EX, and multi-cycle data-memory accesses with a timeout fault.
- Keeps saturating stall and flush performance counters.

Parameters:
- MEM_TIMEOUT, 16: consecutive memory-wait cycles allowed before FAULT. Legal range 1..255.
- STALL_CNT_W, 16: width of the stall_cnt counter.
- ZERO_REG_EN, 1: when 1, rd = 0 never causes a hazard (R0 is hardwired to zero).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_instr  in  16  instruction in ID. rs1 = [7:4], rs2 = [3:0].
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- idex_instr  in  16  instruction in EX. rd = [11:8].
- idex_mem_read  in  1  EX instruction is a load.
- branch_taken  in  1  EX resolved a taken branch.
- exmem_mem_access  in  1  MEM stage performs a load or store this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write_en  out  1  PC register update enable.
- ifid_write_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_write_en  out  1  ID/EX load enable.
- idex_bubble  out  1  ID/EX loads all-zero control and instruction.
- exmem_write_en  out  1  EX/MEM load enable.
- memwb_bubble  out  1  MEM/WB loads zero control (no writeback).
- fault  out  1  memory timeout fault, sticky until reset.
- stall_cnt  out  STALL_CNT_W  saturating count of stall cycles.
- flush_cnt  out  8  saturating count of branch flushes.

Behaviour:
- State register values: RUN, MEM_WAIT, FAULT.
- Reset: state = RUN, wait_cnt = 0, fault = 0, stall_cnt = 0, flush_cnt = 0.
- While rst = 1, all enables and strobes are 0.
- Strobes are combinational from the current state and inputs. fault and the counters are registered.
- Default in RUN with no event: all write enables = 1, all strobes = 0.

Derived signals:
- mem_stall = exmem_mem_access & !dmem_ready.
- load_use = idex_mem_read & !(ZERO_REG_EN & rd == 0) & ((id_uses_rs1 & rs1 == rd) | (id_uses_rs2 & rs2 == rd)).

Priority, highest first:
1. FAULT state: all enables 0, all strobes 0.
2. mem_stall, in RUN or MEM_WAIT:
   - pc, ifid, idex and exmem write enables = 0.
   - memwb_bubble = 1.
   - branch_taken and load_use are ignored this cycle. The EX instruction is frozen, so both are re-evaluated later.
3. branch_taken:
   - pc_write_en = 1 (PC loads the branch target).
   - ifid_flush = 1, idex_bubble = 1.
   - Takes precedence over a simultaneous load_use.
4. load_use:
   - pc_write_en = 0, ifid_write_en = 0, idex_bubble = 1.
   - Lasts exactly one cycle, because the load advances to MEM on the next edge.

State transitions:
- RUN, mem_stall → MEM_WAIT, wait_cnt = 1.
- MEM_WAIT, mem_stall, wait_cnt < MEM_TIMEOUT → stay, wait_cnt + 1.
- MEM_WAIT, mem_stall, wait_cnt == MEM_TIMEOUT → FAULT, fault = 1.
- MEM_WAIT, !mem_stall → RUN, wait_cnt = 0. The pipeline advances in that same cycle, and branch/load_use rules apply.
- FAULT → stays until rst.
- Consequence: MEM_TIMEOUT + 1 consecutive stall cycles are tolerated; fault rises on the following edge.

Counters:
- stall_cnt increments on each cycle with pc_write_en = 0, excluding rst and FAULT. It saturates at all-ones.
- flush_cnt increments on each cycle where priority 3 applies. It saturates at 255.

Reset mid-operation: rst in any state returns all registers to their reset values on the next edge.

Test Plan:
- Load-use: idex_mem_read = 1, idex_instr = 16'h4300, id_instr = 16'h1034, id_uses_rs1 = 1 → one cycle with pc_write_en = 0, ifid_write_en = 0, idex_bubble = 1. Next cycle, with idex_mem_read = 0, all enables = 1. stall_cnt = 1.
- R0 load: idex_instr = 16'h4000, id_instr = 16'h1000, both uses = 1 → no stall, stall_cnt stays 0.
- Branch plus load-use in the same cycle → ifid_flush = 1, idex_bubble = 1, pc_write_en = 1. flush_cnt = 1, stall_cnt unchanged.
- Memory wait: exmem_mem_access = 1, dmem_ready low for 3 cycles then high, MEM_TIMEOUT = 16 → 3 cycles with all enables 0 and memwb_bubble = 1. The 4th cycle advances and the state returns to RUN. stall_cnt = 3.
- Timeout: MEM_TIMEOUT = 4, dmem_ready held 0 → fault = 1 after 5 stall cycles and stays 1 (all outputs 0) when dmem_ready later rises. Cleared only by rst.
- Reset in MEM_WAIT after 2 stall cycles → next cycle state RUN, wait_cnt = 0, stall_cnt = 0, fault = 0.
